parity_stream_checker: RTL and testbench
========================================

PARITY_STREAM_CHECKER -- requirements
Module: parity_stream_checker

Interface
REQ-001 The parameter list SHALL be:
- DATA_W, default 8, word width in bits.
- LANE_W, default 1, bits folded per clock.
REQ-002 Parameter legality SHALL be 1 <= LANE_W <= DATA_W and DATA_W % LANE_W == 0, checked at elaboration; define N = DATA_W/LANE_W.
REQ-003 The port list SHALL be as follows; one clock; reset is asynchronous and active-high:
- clk       in   1       clock, rising edge.
- rst       in   1       asynchronous active-high reset.
- in_valid  in   1       input word valid.
- in_ready  out  1       checker can accept a word.
- in_data   in   DATA_W  word to check.
- in_par    in   1       received parity bit accompanying in_data.
- mode_odd  in   1       0 = even parity, 1 = odd parity.
- out_valid out  1       result valid.
- out_ready in   1       consumer accepts result.
- pec       out  1       computed parity bit.
- err       out  1       computed parity differs from in_par.

Function
REQ-004 pec SHALL equal the XOR of all DATA_W bits of the accepted word, XOR mode_odd; mode 0 gives pec=1 for an odd count of ones.
REQ-005 err SHALL equal pec XOR in_par, with in_par, in_data and mode_odd all sampled at the accepting edge only.
REQ-006 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-007 In IDLE, in_ready=1; in_valid&&in_ready SHALL load the shift register, clear the accumulator and beat counter, and go to SHIFT.
REQ-008 In SHIFT, each edge SHALL fold the low LANE_W bits into the accumulator, shift the register right by LANE_W and increment the beat counter; in_ready=0.
REQ-009 Upon the Nth SHIFT edge the FSM SHALL enter DONE with out_valid=1, pec/err registered; latency from accepting edge to out_valid is exactly N cycles.
REQ-010 In DONE, out_valid, pec and err SHALL hold stable until out_valid&&out_ready.
REQ-011 In DONE, in_ready SHALL equal out_ready.
REQ-012 In DONE, simultaneous out_ready and in_valid SHALL complete the output and accept the new word on the same edge, going directly to SHIFT with no idle bubble.
REQ-013 In DONE, out_ready without in_valid SHALL return the FSM to IDLE with out_valid=0.
REQ-014 Changes on mode_odd, in_par or in_data while not accepting SHALL have no effect.
REQ-015 The beat counter SHALL be $clog2(N)+1 bits wide and SHALL NOT wrap within a word.
REQ-016 With LANE_W=DATA_W (N=1), the FSM SHALL spend exactly one cycle in SHIFT.

Reset
REQ-017 rst SHALL asynchronously force IDLE, out_valid=0, pec=0 and err=0, with shift register, accumulator and counter cleared; in_ready=1 while in reset.
REQ-018 Reset mid-word SHALL discard the word; no out_valid follows release until a new word is accepted.

Configuration
REQ-019 With PARITY_ERR_CNT_EN defined, output err_cnt[15:0] SHALL exist, reset to 0, increment on each out_valid&&out_ready with err=1, and saturate at 16'hFFFF.
REQ-020 Without PARITY_ERR_CNT_EN, the err_cnt port and counter logic SHALL be absent and all other behaviour identical.

Structure
REQ-021 Package parity_pkg SHALL hold:
- State encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
- ERR_CNT_W=16.
- ERR_CNT_MAX constant.
REQ-022 Sub-module parity_lane_xor (combinational LANE_W-bit XOR reduce) SHALL be instantiated once; all sequential logic resides in parity_stream_checker.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with DATA_W=8, LANE_W=1 unless stated:
- 8'hA5, mode_odd=0, in_par=0 -> out_valid exactly 8 cycles after accept, pec=0, err=0.
- 8'h07, mode_odd=0, in_par=0 -> pec=1, err=1; err_cnt 0->1 on out handshake (macro defined).
- 8'h00, mode_odd=1, in_par=1 -> pec=1, err=0; mode_odd toggled mid-SHIFT -> result unchanged.
- out_ready=0 for 5 cycles in DONE -> pec/err/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> new word accepted same edge, state SHIFT next cycle.
- rst pulsed at beat 3 -> out_valid=0, pec=0, err=0 immediately; in_ready=1; no spurious out_valid after release.
- DATA_W=16, LANE_W=4, 16'hFFFF, mode_odd=0 -> out_valid after 4 cycles, pec=0; DATA_W=LANE_W=8, 8'h01 -> out_valid after 1 cycle, pec=1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the parity stream checker.
// Optional feature macro: PARITY_ERR_CNT_EN (adds the err_cnt output).
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int unsigned ERR_CNT_W = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Increment that sticks at the all-ones value
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/parity_lane_xor.sv
// Combinational XOR reduction of one LANE_W-bit lane.
module parity_lane_xor #(
    parameter int unsigned LANE_W = 1
) (
    input  logic [LANE_W-1:0] lane,
    output logic              par_c
);

    // Parity of the lane bits
    assign par_c = ^lane;

endmodule

// File: rtl/parity_stream_checker.sv
// Serial parity checker: folds a word LANE_W bits per clock and reports the
// computed parity and a mismatch flag against the received parity bit.
// Optional feature macro: PARITY_ERR_CNT_EN (saturating 16-bit error counter).
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANE_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              mode_odd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              pec,
    output logic              err
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int unsigned N     = (LANE_W == 0) ? 1 : DATA_W / LANE_W;
    localparam int unsigned CNT_W = $clog2(N) + 1;

    // Reject illegal lane/word geometry at elaboration
    if (LANE_W < 1 || LANE_W > DATA_W || (DATA_W % LANE_W) != 0) begin : g_param_check
        $error("parity_stream_checker: illegal DATA_W=%0d / LANE_W=%0d", DATA_W, LANE_W);
    end

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic              acc;
    logic [CNT_W-1:0]  beat;
    logic              par_q;
    logic              mode_q;
    logic              lane_par;
    logic              fold;
    logic              last_beat;
    logic              accept;

    parity_lane_xor #(
        .LANE_W (LANE_W)
    ) u_lane_xor (
        .lane  (sreg[LANE_W-1:0]),
        .par_c (lane_par)
    );

    assign fold      = acc ^ lane_par;
    assign last_beat = (beat == CNT_W'(N - 1));
    assign accept    = in_valid && in_ready;

    // Ready is decoded from state; in DONE it follows the consumer so a
    // result can retire and a new word load on the same edge
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Control FSM, datapath shift/fold and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sreg      <= '0;
            acc       <= 1'b0;
            beat      <= '0;
            par_q     <= 1'b0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            pec       <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg   <= in_data;
                        acc    <= 1'b0;
                        beat   <= '0;
                        par_q  <= in_par;
                        mode_q <= mode_odd;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc  <= fold;
                    sreg <= sreg >> LANE_W;
                    beat <= beat + CNT_W'(1);
                    if (last_beat) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        pec       <= fold ^ mode_q;
                        err       <= fold ^ mode_q ^ par_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            sreg   <= in_data;
                            acc    <= 1'b0;
                            beat   <= '0;
                            par_q  <= in_par;
                            mode_q <= mode_odd;
                            state  <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PARITY_ERR_CNT_EN
    // Count retired results that flagged a parity error, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker: table of words on the 8/1
// geometry plus hand sequences for stall, back-to-back, reset and the
// 16/4 and 8/8 geometries.
module tb_parity_stream_checker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_par;
    logic        mode_odd;
    logic        out_ready;

    logic ir8,  ov8,  pec8,  err8;
    logic ir16, ov16, pec16, err16;
    logic ir88, ov88, pec88, err88;
`ifdef PARITY_ERR_CNT_EN
    logic [15:0] ec8, ec16, ec88;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    parity_stream_checker #(.DATA_W(8), .LANE_W(1)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir8),
        .in_data(in_data[7:0]), .in_par(in_par), .mode_odd(mode_odd),
        .out_valid(ov8), .out_ready(out_ready), .pec(pec8), .err(err8)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(ec8)
`endif
    );

    parity_stream_checker #(.DATA_W(16), .LANE_W(4)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .in_data(in_data), .in_par(in_par), .mode_odd(mode_odd),
        .out_valid(ov16), .out_ready(out_ready), .pec(pec16), .err(err16)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(ec16)
`endif
    );

    parity_stream_checker #(.DATA_W(8), .LANE_W(8)) u88 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir88),
        .in_data(in_data[7:0]), .in_par(in_par), .mode_odd(mode_odd),
        .out_valid(ov88), .out_ready(out_ready), .pec(pec88), .err(err88)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(ec88)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic       par;
        logic       pec;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sel_ov(input int s);
        case (s)
            0:       return ov8;
            1:       return ov16;
            default: return ov88;
        endcase
    endfunction

    function automatic logic sel_pec(input int s);
        case (s)
            0:       return pec8;
            1:       return pec16;
            default: return pec88;
        endcase
    endfunction

    function automatic logic sel_err(input int s);
        case (s)
            0:       return err8;
            1:       return err16;
            default: return err88;
        endcase
    endfunction

    // Called at the negedge right after the accepting edge; scrambles the
    // non-accepted inputs each cycle and counts edges until out_valid.
    task automatic wait_out(input int sel, output int lat);
        bit done;
        done = 1'b0;
        lat  = -1;
        for (int i = 1; i <= 50 && !done; i++) begin
            in_data  = ~in_data;
            mode_odd = ~mode_odd;
            in_par   = ~in_par;
            @(negedge clk);
            if (sel_ov(sel)) begin
                lat  = i;
                done = 1'b1;
            end
        end
    endtask

    task automatic accept_word(input logic [15:0] d, input logic m, input logic p);
        @(negedge clk);
        in_data  = d;
        mode_odd = m;
        in_par   = p;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_word(input logic [15:0] d, input logic m, input logic p, input int sel,
                            output int lat, output logic pv, output logic ev);
        accept_word(d, m, p);
        wait_out(sel, lat);
        pv = sel_pec(sel);
        ev = sel_err(sel);
        handshake();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        int   lat;
        logic pv, ev;
        bit   spurious;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'hE0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_par    = 1'b0;
        mode_odd  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(ov8), 32'd0);
        check("rst_pec", 32'(pec8), 32'd0);
        check("rst_err", 32'(err8), 32'd0);
        check("rst_in_ready", 32'(ir8), 32'd1);
`ifdef PARITY_ERR_CNT_EN
        check("rst_err_cnt", 32'(ec8), 32'd0);
`endif
        rst = 1'b0;

        // Table of words on the 8-bit, 1-bit-lane checker
        for (int k = 0; k < 8; k++) begin
            run_word(16'(vecs[k].data), vecs[k].mode, vecs[k].par, 0, lat, pv, ev);
            check($sformatf("vec%0d_latency", k), 32'(lat), 32'd8);
            check($sformatf("vec%0d_pec", k), 32'(pv), 32'(vecs[k].pec));
            check($sformatf("vec%0d_err", k), 32'(ev), 32'(vecs[k].err));
            if (vecs[k].err) exp_cnt++;
`ifdef PARITY_ERR_CNT_EN
            check($sformatf("vec%0d_err_cnt", k), 32'(ec8), 32'(exp_cnt));
`endif
        end

        // Stall in DONE, then retire and accept on the same edge
        accept_word(16'h0007, 1'b0, 1'b0);
        wait_out(0, lat);
        check("stall_latency", 32'(lat), 32'd8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_out_valid", k), 32'(ov8), 32'd1);
            check($sformatf("stall%0d_pec", k), 32'(pec8), 32'd1);
            check($sformatf("stall%0d_err", k), 32'(err8), 32'd1);
            check($sformatf("stall%0d_in_ready", k), 32'(ir8), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h00A5;
        mode_odd  = 1'b0;
        in_par    = 1'b0;
        #1;
        check("b2b_in_ready_follows", 32'(ir8), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_cnt++;
        check("b2b_out_valid_drop", 32'(ov8), 32'd0);
        check("b2b_in_shift", 32'(ir8), 32'd0);
`ifdef PARITY_ERR_CNT_EN
        check("b2b_err_cnt", 32'(ec8), 32'(exp_cnt));
`endif
        wait_out(0, lat);
        check("b2b_latency", 32'(lat), 32'd8);
        check("b2b_pec", 32'(pec8), 32'd0);
        check("b2b_err", 32'(err8), 32'd0);
        handshake();

        // Reset at beat 3 with non-zero pec/err left from the prior word
        run_word(16'h0007, 1'b0, 1'b0, 0, lat, pv, ev);
        check("pre_rst_pec", 32'(pec8), 32'd1);
        check("pre_rst_err", 32'(err8), 32'd1);
        accept_word(16'h00FF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(ov8), 32'd0);
        check("midrst_pec", 32'(pec8), 32'd0);
        check("midrst_err", 32'(err8), 32'd0);
        check("midrst_in_ready", 32'(ir8), 32'd1);
`ifdef PARITY_ERR_CNT_EN
        check("midrst_err_cnt", 32'(ec8), 32'd0);
`endif
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ov8) spurious = 1'b1;
        end
        check("post_rst_no_out_valid", 32'(spurious), 32'd0);
        check("post_rst_in_ready", 32'(ir8), 32'd1);

        // 16-bit word, 4-bit lanes
        do_reset();
        run_word(16'hFFFF, 1'b0, 1'b0, 1, lat, pv, ev);
        check("w16_latency", 32'(lat), 32'd4);
        check("w16_pec", 32'(pv), 32'd0);
        check("w16_err", 32'(ev), 32'd0);

        // Single-lane word: one cycle in SHIFT
        do_reset();
        run_word(16'h0001, 1'b0, 1'b0, 2, lat, pv, ev);
        check("w88_latency", 32'(lat), 32'd1);
        check("w88_pec", 32'(pv), 32'd1);
        check("w88_err", 32'(ev), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
